// File: rtl/tile_entity_scheduler.sv
// -----------------------------------------------------------------------------
// tile_entity_scheduler
//
// Purpose:
//    For one screen tile, scans a bank of entity slots through an external
//    registered slot mux. It picks the highest-index slot whose sprite covers
//    that tile. It then presents a single ROM lookup request (sprite ID,
//    orientation, line) with a valid/ready handshake. If no slot matches, the
//    request is a "blank" one.
//
// Ports:
//    clk            sole clock, rising edge
//    reset          synchronous, active-high reset
//    tile_start     one-cycle pulse: schedule tile (tile_h, tile_v, line_in)
//    tile_h/tile_v  tile indices to schedule
//    line_in        sprite row 0..7 within the tile
//    slot_sel       slot index driven to the external slot mux
//    slot_data      slot word, valid one cycle after slot_sel
//                   [17:14] id, [13:12] orient, [11:8] H, [7:4] V, [3:0] len
//    slot_flag      slot mode: 00 normal, 01 flip, 10 array, 11 disabled
//    req_valid      ROM request valid (held until req_ready)
//    req_ready      ROM side accepts the request
//    req_sprite_id  winning sprite ID
//    req_orient     winning orientation
//    req_line       line index for the ROM
//    busy           high whenever not IDLE
//    overrun        one-cycle pulse: a tile_start was dropped
//    match_count    matching slots found by the last completed scan
// -----------------------------------------------------------------------------
module tile_entity_scheduler #(
   parameter int         NUM_SLOTS = 15,
   parameter logic [3:0] EMPTY_ID  = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tile_start,
   input  logic [3:0]  tile_h,
   input  logic [3:0]  tile_v,
   input  logic [2:0]  line_in,
   output logic [3:0]  slot_sel,
   input  logic [17:0] slot_data,
   input  logic [1:0]  slot_flag,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [3:0]  req_sprite_id,
   output logic [1:0]  req_orient,
   output logic [2:0]  req_line,
   output logic        busy,
   output logic        overrun,
   output logic [4:0]  match_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PRESENT = 2'd2
   } state_t;

   localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
   // The scan cycle counter reaches NUM_SLOTS when the last slot's data is on
   // the bus. This is because the slot mux adds one cycle of read latency.
   localparam logic [4:0] SCAN_END  = 5'(NUM_SLOTS);

   localparam logic [3:0] BLANK_ID     = 4'hF;
   localparam logic [1:0] BLANK_ORIENT = 2'b11;
   localparam logic [2:0] BLANK_LINE   = 3'b111;

   state_t      state_q, state_d;
   logic [3:0]  tile_h_q, tile_h_d;
   logic [3:0]  tile_v_q, tile_v_d;
   logic [2:0]  line_q, line_d;
   logic [3:0]  slot_sel_q, slot_sel_d;
   logic [4:0]  scan_cnt_q, scan_cnt_d;
   logic [4:0]  hit_cnt_q, hit_cnt_d;
   logic [4:0]  match_count_q, match_count_d;
   logic [3:0]  win_id_q, win_id_d;
   logic [1:0]  win_orient_q, win_orient_d;
   logic [2:0]  win_line_q, win_line_d;
   logic        req_valid_q, req_valid_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;

   // Slot word fields
   logic [3:0]  s_id;
   logic [1:0]  s_orient;
   logic [3:0]  s_h, s_v, s_len;
   logic [4:0]  s_h_end;
   logic        s_hit;
   logic        handshake;
   logic        start;

   assign s_id     = slot_data[17:14];
   assign s_orient = slot_data[13:12];
   assign s_h      = slot_data[11:8];
   assign s_v      = slot_data[7:4];
   assign s_len    = slot_data[3:0];
   // The array span end is kept at 5 bits so that an array reaching past
   // column 15 does not wrap around to the low columns.
   assign s_h_end  = {1'b0, s_h} + {1'b0, s_len};

   always_comb begin
      s_hit = 1'b0;
      if (s_id != EMPTY_ID && slot_flag != 2'b11 && s_v == tile_v_q) begin
         if (slot_flag == 2'b10)
            s_hit = (tile_h_q >= s_h) && ({1'b0, tile_h_q} <= s_h_end);
         else
            s_hit = (s_h == tile_h_q);
      end
   end

   assign handshake = (state_q == PRESENT) && req_ready;
   // A start is accepted in IDLE, or in the same cycle as a PRESENT handshake.
   assign start     = tile_start && ((state_q == IDLE) || handshake);

   // NOTE: every variable is defaulted at the top so no path leaves it
   // unassigned; an incomplete always_comb would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      tile_h_d      = tile_h_q;
      tile_v_d      = tile_v_q;
      line_d        = line_q;
      slot_sel_d    = slot_sel_q;
      scan_cnt_d    = scan_cnt_q;
      hit_cnt_d     = hit_cnt_q;
      match_count_d = match_count_q;
      win_id_d      = win_id_q;
      win_orient_d  = win_orient_q;
      win_line_d    = win_line_q;
      overrun_d     = 1'b0;

      case (state_q)
         SCAN: begin
            overrun_d  = tile_start;
            scan_cnt_d = scan_cnt_q + 5'd1;
            if (slot_sel_q != LAST_SLOT)
               slot_sel_d = slot_sel_q + 4'd1;
            // In cycle 0 the mux has not produced data yet. From cycle 1 on,
            // the bus carries slot (scan_cnt_q - 1). A later hit overwrites
            // an earlier one, so the highest index wins.
            if (scan_cnt_q != 5'd0 && s_hit) begin
               if (hit_cnt_q != 5'd31)
                  hit_cnt_d = hit_cnt_q + 5'd1;
               win_id_d     = s_id;
               win_orient_d = s_orient;
               win_line_d   = (slot_flag == 2'b01) ? ~line_q : line_q;
            end
            if (scan_cnt_q == SCAN_END) begin
               state_d       = PRESENT;
               match_count_d = hit_cnt_d;
            end
         end
         PRESENT: begin
            if (handshake)
               state_d = IDLE;
            else
               overrun_d = tile_start;
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d      = SCAN;
         tile_h_d     = tile_h;
         tile_v_d     = tile_v;
         line_d       = line_in;
         slot_sel_d   = 4'd0;
         scan_cnt_d   = 5'd0;
         hit_cnt_d    = 5'd0;
         win_id_d     = BLANK_ID;
         win_orient_d = BLANK_ORIENT;
         win_line_d   = BLANK_LINE;
      end

      busy_d      = (state_d != IDLE);
      req_valid_d = (state_d == PRESENT);
   end

   // NOTE: state is updated only with non-blocking assignments, so every
   // flop samples the values from before the edge, regardless of statement
   // order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         tile_h_q      <= 4'd0;
         tile_v_q      <= 4'd0;
         line_q        <= 3'd0;
         slot_sel_q    <= 4'd0;
         scan_cnt_q    <= 5'd0;
         hit_cnt_q     <= 5'd0;
         match_count_q <= 5'd0;
         win_id_q      <= BLANK_ID;
         win_orient_q  <= BLANK_ORIENT;
         win_line_q    <= BLANK_LINE;
         req_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         tile_h_q      <= tile_h_d;
         tile_v_q      <= tile_v_d;
         line_q        <= line_d;
         slot_sel_q    <= slot_sel_d;
         scan_cnt_q    <= scan_cnt_d;
         hit_cnt_q     <= hit_cnt_d;
         match_count_q <= match_count_d;
         win_id_q      <= win_id_d;
         win_orient_q  <= win_orient_d;
         win_line_q    <= win_line_d;
         req_valid_q   <= req_valid_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
      end
   end

   assign slot_sel      = slot_sel_q;
   assign req_valid     = req_valid_q;
   assign req_sprite_id = win_id_q;
   assign req_orient    = win_orient_q;
   assign req_line      = win_line_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;
   assign match_count   = match_count_q;

endmodule

// File: tb/tb_tile_entity_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tile_entity_scheduler
//
// Directed bench for tile_entity_scheduler. A behavioural slot memory models
// the external registered slot mux. Each step drives a tile and compares
// the presented request against hand-computed values.
// -----------------------------------------------------------------------------
module tb_tile_entity_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        tile_start;
   logic [3:0]  tile_h, tile_v;
   logic [2:0]  line_in;
   logic [3:0]  slot_sel;
   logic [17:0] slot_data;
   logic [1:0]  slot_flag;
   logic        req_valid, req_ready;
   logic [3:0]  req_sprite_id;
   logic [1:0]  req_orient;
   logic [2:0]  req_line;
   logic        busy, overrun;
   logic [4:0]  match_count;

   int checks = 0;
   int fails  = 0;

   logic [17:0] slot_mem [16];
   logic [1:0]  flag_mem [16];

   tile_entity_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .tile_start    (tile_start),
      .tile_h        (tile_h),
      .tile_v        (tile_v),
      .line_in       (line_in),
      .slot_sel      (slot_sel),
      .slot_data     (slot_data),
      .slot_flag     (slot_flag),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_sprite_id (req_sprite_id),
      .req_orient    (req_orient),
      .req_line      (req_line),
      .busy          (busy),
      .overrun       (overrun),
      .match_count   (match_count)
   );

   always #5 clk = ~clk;

   // The external slot mux has a registered read of one cycle.
   always @(posedge clk) begin
      slot_data <= slot_mem[slot_sel];
      slot_flag <= flag_mem[slot_sel];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_slots();
      for (int i = 0; i < 16; i++) begin
         slot_mem[i] = {4'hF, 2'b00, 4'h0, 4'h0, 4'h0};
         flag_mem[i] = 2'b00;
      end
   endtask

   function automatic logic [17:0] word(input logic [3:0] id, input logic [1:0] o,
                                        input logic [3:0] h, input logic [3:0] v,
                                        input logic [3:0] len);
      return {id, o, h, v, len};
   endfunction

   // Pulses tile_start for one cycle. The task returns at the negedge after
   // the accepting edge.
   task automatic pulse_start(input logic [3:0] h, input logic [3:0] v, input logic [2:0] l);
      @(negedge clk);
      tile_start = 1'b1;
      tile_h     = h;
      tile_v     = v;
      line_in    = l;
      @(negedge clk);
      tile_start = 1'b0;
   endtask

   // Starts at the negedge after the accepting edge. req_valid must first
   // show 16 negedges later, which is T+17.
   task automatic expect_present(input string tag);
      int seen_early = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (req_valid) seen_early++;
      end
      check({tag, "_early_valid"}, seen_early, 0);
      @(negedge clk);
      check({tag, "_valid"}, req_valid, 1'b1);
   endtask

   task automatic expect_req(input string tag, input logic [3:0] id, input logic [1:0] o,
                             input logic [2:0] l, input logic [4:0] cnt);
      check({tag, "_req"}, {req_sprite_id, req_orient, req_line}, {id, o, l});
      check({tag, "_count"}, match_count, cnt);
   endtask

   task automatic accept(input string tag);
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check({tag, "_done"}, {req_valid, busy}, 2'b00);
   endtask

   task automatic run_tile(input string tag, input logic [3:0] h, input logic [3:0] v,
                           input logic [2:0] l, input logic [3:0] id, input logic [1:0] o,
                           input logic [2:0] el, input logic [4:0] cnt);
      pulse_start(h, v, l);
      expect_present(tag);
      expect_req(tag, id, o, el, cnt);
      accept(tag);
   endtask

   initial begin
      reset      = 1'b1;
      tile_start = 1'b0;
      tile_h     = 4'd0;
      tile_v     = 4'd0;
      line_in    = 3'd0;
      req_ready  = 1'b0;
      clear_slots();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ctrl", {req_valid, busy, overrun, slot_sel}, 7'b000_0000);
      expect_req("rst", 4'hF, 2'b11, 3'b111, 5'd0);
      reset = 1'b0;

      // Single hit in slot 3
      slot_mem[3] = word(4'd2, 2'd1, 4'd5, 4'd4, 4'd0);
      run_tile("single", 4'd5, 4'd4, 3'd6, 4'd2, 2'd1, 3'd6, 5'd1);
      check("single_count_hold", match_count, 5'd1);

      // Priority: slot 9 (flip) beats slot 2. The line is inverted: ~2 = 5.
      clear_slots();
      slot_mem[2] = word(4'd3, 2'd0, 4'd1, 4'd1, 4'd0);
      slot_mem[9] = word(4'd7, 2'd2, 4'd1, 4'd1, 4'd0);
      flag_mem[9] = 2'b01;
      run_tile("prio", 4'd1, 4'd1, 3'd2, 4'd7, 2'd2, 3'd5, 5'd2);

      // Array spanning H13..17, clipped at 15
      clear_slots();
      slot_mem[1] = word(4'd5, 2'd3, 4'd13, 4'd0, 4'd4);
      flag_mem[1] = 2'b10;
      run_tile("arr_h13", 4'd13, 4'd0, 3'd1, 4'd5, 2'd3, 3'd1, 5'd1);
      run_tile("arr_h14", 4'd14, 4'd0, 3'd2, 4'd5, 2'd3, 3'd2, 5'd1);
      run_tile("arr_h15", 4'd15, 4'd0, 3'd3, 4'd5, 2'd3, 3'd3, 5'd1);
      run_tile("arr_h12", 4'd12, 4'd0, 3'd4, 4'hF, 2'b11, 3'b111, 5'd0);

      // Array at H15 with len 15: a 4-bit sum would wrap to 14.
      slot_mem[1] = word(4'd6, 2'd0, 4'd15, 4'd0, 4'd15);
      run_tile("edge_h15", 4'd15, 4'd0, 3'd0, 4'd6, 2'd0, 3'd0, 5'd1);
      run_tile("edge_h14", 4'd14, 4'd0, 3'd0, 4'hF, 2'b11, 3'b111, 5'd0);
      run_tile("edge_h0", 4'd0, 4'd0, 3'd0, 4'hF, 2'b11, 3'b111, 5'd0);

      // Overrun during SCAN leaves the scan intact.
      clear_slots();
      slot_mem[3] = word(4'd2, 2'd1, 4'd5, 4'd4, 4'd0);
      pulse_start(4'd5, 4'd4, 3'd6);
      repeat (3) @(negedge clk);
      tile_start = 1'b1;
      tile_h     = 4'd0;
      tile_v     = 4'd0;
      @(negedge clk);
      tile_start = 1'b0;
      check("scan_overrun", overrun, 1'b1);
      @(negedge clk);
      check("scan_overrun_clear", overrun, 1'b0);
      // 5 of 16 negedges are used; 10 more leave the bench one short of presenting.
      repeat (10) @(negedge clk);
      check("scan_ovr_not_yet", req_valid, 1'b0);
      @(negedge clk);
      check("scan_ovr_valid", req_valid, 1'b1);
      expect_req("scan_ovr", 4'd2, 2'd1, 3'd6, 5'd1);

      // Backpressure: the request stays stable for 10 cycles while ready is low.
      begin
         int unstable = 0;
         for (int i = 0; i < 10; i++) begin
            if (i == 4) tile_start = 1'b1;
            @(negedge clk);
            tile_start = 1'b0;
            if (i == 4) check("bp_overrun", overrun, 1'b1);
            if (i == 5) check("bp_overrun_clear", overrun, 1'b0);
            if ({req_valid, req_sprite_id, req_orient, req_line, match_count} !==
                {1'b1, 4'd2, 2'd1, 3'd6, 5'd1}) unstable++;
         end
         check("bp_stable", unstable, 0);
      end

      // Handshake and tile_start in the same cycle start a new scan.
      clear_slots();
      slot_mem[0] = word(4'd9, 2'd2, 4'd7, 4'd8, 4'd0);
      req_ready  = 1'b1;
      tile_start = 1'b1;
      tile_h     = 4'd7;
      tile_v     = 4'd8;
      line_in    = 3'd3;
      @(negedge clk);
      req_ready  = 1'b0;
      tile_start = 1'b0;
      check("hs_restart", {req_valid, busy, overrun}, 3'b010);
      expect_present("hs_scan");
      expect_req("hs_scan", 4'd9, 2'd2, 3'd3, 5'd1);
      accept("hs_scan");

      // All slots empty; also keep ready high during SCAN, where it is ignored.
      clear_slots();
      req_ready = 1'b1;
      pulse_start(4'd5, 4'd4, 3'd6);
      req_ready = 1'b0;
      expect_present("empty");
      expect_req("empty", 4'hF, 2'b11, 3'b111, 5'd0);
      accept("empty");

      // Slots that would match, but all are disabled
      for (int i = 0; i < 16; i++) begin
         slot_mem[i] = word(4'd1, 2'd0, 4'd5, 4'd4, 4'd0);
         flag_mem[i] = 2'b11;
      end
      run_tile("disabled", 4'd5, 4'd4, 3'd6, 4'hF, 2'b11, 3'b111, 5'd0);

      // Reset mid-scan at T+8, then a normal scan
      clear_slots();
      slot_mem[14] = word(4'd4, 2'd1, 4'd2, 4'd3, 4'd0);
      pulse_start(4'd2, 4'd3, 3'd1);
      repeat (7) @(negedge clk);
      reset      = 1'b1;
      tile_start = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      tile_start = 1'b0;
      check("midrst", {req_valid, busy, slot_sel}, 6'b00_0000);
      repeat (20) @(negedge clk);
      check("midrst_no_req", {req_valid, busy}, 2'b00);
      run_tile("after_rst", 4'd2, 4'd3, 3'd1, 4'd4, 2'd1, 3'd1, 5'd1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   // Watchdog: ends the run even if a bounded loop somehow stalls.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tile_entity_scheduler.md
TILE_ENTITY_SCHEDULER -- requirements
Module: tile_entity_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 15, number of entity slots scanned per tile (legal 1..15).
REQ-002 Parameter EMPTY_ID, default 4'hF, sprite ID marking an unused slot.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tile_start  input  1  one-cycle pulse: schedule the tile given by tile_h/tile_v/line_in.
REQ-006 tile_h  input  4  horizontal tile index of the tile to schedule.
REQ-007 tile_v  input  4  vertical tile index of the tile to schedule.
REQ-008 line_in  input  3  sprite line (row 0..7) within that tile.
REQ-009 slot_sel  output  4  index of the slot currently addressed in the external slot mux.
REQ-010 slot_data  input  18  slot word: [17:14] sprite ID, [13:12] orientation, [11:8] H tile, [7:4] V tile, [3:0] array length; registered read, valid one cycle after slot_sel.
REQ-011 slot_flag  input  2  slot mode, same timing as slot_data: 00 normal, 01 flip, 10 array, 11 disabled.
REQ-012 req_valid  output  1  ROM lookup request valid.
REQ-013 req_ready  input  1  ROM side accepts the request.
REQ-014 req_sprite_id  output  4  winning sprite ID.
REQ-015 req_orient  output  2  winning orientation.
REQ-016 req_line  output  3  line index for the ROM.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 overrun  output  1  one-cycle pulse: tile_start arrived while busy and was dropped.
REQ-019 match_count  output  5  number of matching slots found by the last completed scan.

Function
REQ-020 States SHALL be IDLE, SCAN, PRESENT; no other states are reachable.
REQ-021 In IDLE, tile_start SHALL latch tile_h, tile_v and line_in, clear the winner and match counter, set slot_sel to 0, and move to SCAN.
REQ-022 In SCAN, slot_sel SHALL increment by 1 each cycle up to NUM_SLOTS-1 and then hold.
REQ-023 slot_data/slot_flag sampled in the cycle after slot_sel = k SHALL be evaluated as slot k.
REQ-024 A slot SHALL match when ID != EMPTY_ID, flag != 11, and [7:4] == latched V.
  - Flags 00/01: [11:8] == latched H.
  - Flag 10: latched H lies in [H_pos, H_pos + len], with the sum computed in 5 bits (no wrap past 15).
REQ-025 On a match, match_count SHALL increment, saturating at 31.
REQ-026 On a match, the winner SHALL become this slot: highest-index matching slot wins.
REQ-027 Winner line SHALL be ~line_in for flag 01 and line_in otherwise.
REQ-028 After slot NUM_SLOTS-1 is evaluated, the block SHALL enter PRESENT with req_valid = 1.
  - Timing: tile_start in cycle T gives first req_valid in cycle T+NUM_SLOTS+2 (T+17 at default).
REQ-029 If no slot matched, PRESENT SHALL drive the blank request: sprite_id 4'hF, orient 2'b11, line 3'b111.
REQ-030 In PRESENT, req_valid and all req_* fields SHALL hold stable until the cycle in which req_valid and req_ready are both 1.
  - The next state after that cycle is IDLE.
REQ-031 match_count SHALL update on entry to PRESENT and hold until the next entry to PRESENT.
REQ-032 tile_start in SCAN, or in PRESENT without handshake, SHALL be dropped and SHALL pulse overrun for one cycle; the scan in progress is unaffected.
REQ-033 tile_start in the same cycle as the PRESENT handshake SHALL be accepted as in IDLE: next state SCAN, no overrun, req_valid low the following cycle.
REQ-034 req_ready SHALL be ignored outside PRESENT.

Reset
REQ-035 While reset = 1 the state SHALL be IDLE and outputs SHALL be: req_valid 0, busy 0, overrun 0, slot_sel 0, match_count 0, req_sprite_id 4'hF, req_orient 2'b11, req_line 3'b111.
REQ-036 Reset asserted mid-SCAN or mid-PRESENT SHALL abandon the operation with no request issued; tile_start in the reset cycle is ignored.

Verification
REQ-037 Single hit: slot 3 = ID 2, orient 1, H 5, V 4, flag 00; tile_start(H5, V4, line 6) -> req_valid at T+17 with id 2, orient 1, line 6; match_count 1.
REQ-038 Priority and flip: slots 2 and 9 both at (H1, V1), slot 9 ID 7 flag 01; line 2 -> id 7, line 5; match_count 2.
REQ-039 Array and edge cases:
  - Slot 1 flag 10, H 13, V 0, len 4; tiles H13..15 -> hit; H12 -> blank.
  - H_pos 15, len 15: only H15 hits.
REQ-040 Backpressure and overrun: hold req_ready = 0 for 10 cycles -> request stable; tile_start during that window -> overrun pulse, no new scan; ready plus tile_start in the same cycle -> new scan, no overrun.
REQ-041 Empty and disabled: all slots EMPTY_ID, or flag 11 -> blank request, match_count 0.
REQ-042 Reset mid-scan at T+8 -> next cycle busy 0, req_valid 0; a subsequent tile_start completes normally.
